// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, data width and queued command record
package alu_pkg;

   localparam int DATA_W    = 32;
   // Widest tag the command record can carry; narrower tags are zero-extended.
   localparam int CMD_TAG_W = 8;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;

   typedef struct packed {
      logic [2:0]           sel;
      logic [DATA_W-1:0]    a;
      logic [DATA_W-1:0]    b;
      logic                 fwd_a;
      logic                 fwd_b;
      logic [CMD_TAG_W-1:0] tag;
   } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - in-order command FIFO with synchronous flush
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  alu_cmd_t                     wdata,
   output alu_cmd_t                     rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   alu_cmd_t      mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   // Flush wins over both ports so a same-cycle push is discarded.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - operand issue stage feeding the registered ALU
// Queues commands, forwards R into operands and stalls one cycle on a fresh result.
module alu_issue
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
)
(
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         IN_VALID,
   output logic                         IN_READY,
   input  logic [2:0]                   IN_SEL,
   input  logic [DATA_W-1:0]            IN_A,
   input  logic [DATA_W-1:0]            IN_B,
   input  logic                         IN_FWD_A,
   input  logic                         IN_FWD_B,
   input  logic [TAG_W-1:0]             IN_TAG,
   input  logic                         HOLD,
   input  logic                         FLUSH,
   input  logic [DATA_W-1:0]            R,
   output logic [DATA_W-1:0]            A,
   output logic [DATA_W-1:0]            B,
   output logic [2:0]                   SEL,
   output logic                         ISSUE,
   output logic                         RES_VALID,
   output logic [TAG_W-1:0]             RES_TAG,
   output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

   alu_cmd_t         in_cmd;
   alu_cmd_t         head;
   logic             full;
   logic             empty;
   logic             push;
   logic             head_fwd;
   logic             issue_go;
   logic [TAG_W-1:0] issue_tag;

   always_comb begin
      in_cmd       = '0;
      in_cmd.sel   = IN_SEL;
      in_cmd.a     = IN_A;
      in_cmd.b     = IN_B;
      in_cmd.fwd_a = IN_FWD_A;
      in_cmd.fwd_b = IN_FWD_B;
      in_cmd.tag   = CMD_TAG_W'(IN_TAG);
   end

   assign IN_READY = !full;
   assign push     = IN_VALID && IN_READY;
   assign head_fwd = head.fwd_a || head.fwd_b;
   // R lags the last issue by a cycle, so a forwarding head waits out ISSUE.
   assign issue_go = !empty && !HOLD && !FLUSH && !(head_fwd && ISSUE);

   alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push),
      .pop   (issue_go),
      .flush (FLUSH),
      .wdata (in_cmd),
      .rdata (head),
      .count (COUNT),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         A         <= '0;
         B         <= '0;
         SEL       <= 3'b000;
         ISSUE     <= 1'b0;
         issue_tag <= '0;
         RES_VALID <= 1'b0;
         RES_TAG   <= '0;
      end else begin
         RES_VALID <= ISSUE;
         RES_TAG   <= issue_tag;
         if (issue_go) begin
            SEL       <= head.sel;
            A         <= head.fwd_a ? R : head.a;
            B         <= head.fwd_b ? R : head.b;
            ISSUE     <= 1'b1;
            issue_tag <= TAG_W'(head.tag);
         end else begin
            ISSUE     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed bench for alu_issue with a queue-level reference model
module tb_alu_issue;
   import alu_pkg::*;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic             CLK = 1'b0;
   logic             RST;
   logic             IN_VALID;
   logic             IN_READY;
   logic [2:0]       IN_SEL;
   logic [31:0]      IN_A;
   logic [31:0]      IN_B;
   logic             IN_FWD_A;
   logic             IN_FWD_B;
   logic [TAG_W-1:0] IN_TAG;
   logic             HOLD;
   logic             FLUSH;
   logic [31:0]      R;
   logic [31:0]      A;
   logic [31:0]      B;
   logic [2:0]       SEL;
   logic             ISSUE;
   logic             RES_VALID;
   logic [TAG_W-1:0] RES_TAG;
   logic [2:0]       COUNT;

   int n_tests = 0;
   int n_fail  = 0;

   alu_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .IN_SEL(IN_SEL), .IN_A(IN_A), .IN_B(IN_B), .IN_FWD_A(IN_FWD_A),
      .IN_FWD_B(IN_FWD_B), .IN_TAG(IN_TAG), .HOLD(HOLD), .FLUSH(FLUSH),
      .R(R), .A(A), .B(B), .SEL(SEL), .ISSUE(ISSUE), .RES_VALID(RES_VALID),
      .RES_TAG(RES_TAG), .COUNT(COUNT)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] alu_f(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
      case (s)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a + b;
         3'd3:    return a - b;
         3'd4:    return a * b;
         3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Registered ALU downstream of the issue stage.
   always @(posedge CLK or posedge RST) begin
      if (RST) R <= 32'd0;
      else     R <= alu_f(SEL, A, B);
   end

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endfunction

   // Reference model: a command queue plus the value of the last issued result.
   typedef struct {
      logic [2:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic        fa;
      logic        fb;
      logic [3:0]  tag;
   } cmd_t;

   cmd_t        q[$];
   cmd_t        m_c;
   cmd_t        m_n;
   bit          m_go;
   bit          m_push;
   logic [31:0] m_a = 0, m_b = 0, m_last = 0, m_pend = 0, m_res = 0;
   logic [2:0]  m_sel = 0;
   logic        m_issue = 0, m_rv = 0;
   logic [3:0]  m_itag = 0, m_rtag = 0;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         q.delete();
         m_a = 0; m_b = 0; m_sel = 0; m_last = 0; m_pend = 0; m_res = 0;
         m_issue = 0; m_rv = 0; m_itag = 0; m_rtag = 0;
      end else begin
         m_rv   = m_issue;
         m_rtag = m_itag;
         m_res  = m_pend;
         m_push = IN_VALID && (q.size() < DEPTH) && !FLUSH;
         m_n    = '{IN_SEL, IN_A, IN_B, IN_FWD_A, IN_FWD_B, IN_TAG};
         m_go   = (q.size() > 0) && !HOLD && !FLUSH;
         if (m_go && (q[0].fa || q[0].fb) && m_issue) m_go = 0;
         if (m_go) begin
            m_c     = q.pop_front();
            m_a     = m_c.fa ? m_last : m_c.a;
            m_b     = m_c.fb ? m_last : m_c.b;
            m_sel   = m_c.sel;
            m_pend  = alu_f(m_c.sel, m_a, m_b);
            m_last  = m_pend;
            m_issue = 1;
            m_itag  = m_c.tag;
         end else begin
            m_issue = 0;
         end
         if (FLUSH) q.delete();
         if (m_push) q.push_back(m_n);
      end
   end

   always @(negedge CLK) begin
      if (!RST) begin
         check("m.A", A, m_a);
         check("m.B", B, m_b);
         check("m.SEL", 32'(SEL), 32'(m_sel));
         check("m.ISSUE", 32'(ISSUE), 32'(m_issue));
         check("m.RES_VALID", 32'(RES_VALID), 32'(m_rv));
         check("m.RES_TAG", 32'(RES_TAG), 32'(m_rtag));
         check("m.COUNT", 32'(COUNT), q.size());
         check("m.IN_READY", 32'(IN_READY), 32'(q.size() < DEPTH));
         if (m_rv) check("m.R", R, m_res);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                        input logic fa, input logic fb, input logic [3:0] t);
      IN_VALID = 1; IN_SEL = s; IN_A = a; IN_B = b; IN_FWD_A = fa; IN_FWD_B = fb; IN_TAG = t;
   endtask

   task automatic idle();
      IN_VALID = 0; IN_FWD_A = 0; IN_FWD_B = 0;
   endtask

   initial begin
      RST = 1; HOLD = 0; FLUSH = 0;
      IN_SEL = 0; IN_A = 0; IN_B = 0; IN_TAG = 0;
      idle();
      repeat (2) @(posedge CLK);
      #1;
      check("rst.A", A, 0);
      check("rst.B", B, 0);
      check("rst.SEL", 32'(SEL), 0);
      check("rst.ISSUE", 32'(ISSUE), 0);
      check("rst.RES_VALID", 32'(RES_VALID), 0);
      check("rst.RES_TAG", 32'(RES_TAG), 0);
      check("rst.COUNT", 32'(COUNT), 0);
      check("rst.IN_READY", 32'(IN_READY), 1);
      RST = 0;
      tick();

      // Single ADD 5+7
      drive(OP_ADD, 5, 7, 0, 0, 1);
      tick(); idle();
      check("add.issue_early", 32'(ISSUE), 0);
      tick();
      check("add.ISSUE", 32'(ISSUE), 1);
      check("add.SEL", 32'(SEL), 2);
      check("add.A", A, 5);
      check("add.B", B, 7);
      tick();
      check("add.RES_VALID", 32'(RES_VALID), 1);
      check("add.RES_TAG", 32'(RES_TAG), 1);
      check("add.R", R, 12);

      // Dependent SUB forwarding the ADD result into A
      drive(OP_ADD, 3, 4, 0, 0, 2);
      tick();
      drive(OP_SUB, 99, 2, 1, 0, 3);
      tick(); idle();
      check("dep.first_issue", 32'(ISSUE), 1);
      check("dep.first_A", A, 3);
      tick();
      check("dep.bubble", 32'(ISSUE), 0);
      check("dep.add_R", R, 7);
      check("dep.add_tag", 32'(RES_TAG), 2);
      tick();
      check("dep.second_issue", 32'(ISSUE), 1);
      check("dep.fwd_A", A, 7);
      check("dep.B", B, 2);
      check("dep.SEL", 32'(SEL), 3);
      tick();
      check("dep.RES_VALID", 32'(RES_VALID), 1);
      check("dep.RES_TAG", 32'(RES_TAG), 3);
      check("dep.R", R, 5);

      // MUL forwarding into B after R has settled at 5
      drive(OP_MUL, 6, 0, 0, 1, 4);
      tick(); idle();
      tick();
      check("fwdb.B", B, 5);
      tick();
      check("fwdb.R", R, 30);
      check("fwdb.RES_TAG", 32'(RES_TAG), 4);

      // Fill under HOLD, fifth push refused, then drain in order
      HOLD = 1;
      for (int i = 0; i < 5; i++) begin
         check("fill.IN_READY", 32'(IN_READY), 32'(i < 4));
         case (i)
            0: drive(OP_AND, 32'hff00ff00, 32'h0ff00ff0, 0, 0, 5);
            1: drive(OP_OR, 32'h00000f00, 32'h000000f0, 0, 0, 6);
            2: drive(OP_SLT, 32'hfffffffd, 32'd2, 0, 0, 7);
            3: drive(3'b110, 32'd9, 32'd9, 0, 0, 8);
            default: drive(OP_SUB, 32'd1, 32'd1, 0, 0, 9);
         endcase
         tick();
      end
      idle();
      check("fill.COUNT", 32'(COUNT), 4);
      check("fill.IN_READY_full", 32'(IN_READY), 0);
      HOLD = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("drain.ISSUE", 32'(ISSUE), 1);
         check("drain.COUNT", 32'(COUNT), 32'(3 - i));
         if (i > 0) check("drain.RES_TAG", 32'(RES_TAG), 32'(5 + i - 1));
      end
      tick();
      check("drain.idle", 32'(ISSUE), 0);
      check("drain.op110_R", R, 0);

      // FLUSH with three queued and a concurrent push
      HOLD = 1;
      for (int i = 0; i < 3; i++) begin
         drive(OP_ADD, 32'(i), 32'(i), 0, 0, 4'(10 + i));
         tick();
      end
      drive(OP_ADD, 32'd77, 32'd1, 0, 0, 4'd13);
      FLUSH = 1;
      tick();
      idle(); FLUSH = 0; HOLD = 0;
      check("flush.COUNT", 32'(COUNT), 0);
      check("flush.ISSUE", 32'(ISSUE), 0);
      check("flush.A", A, 9);
      check("flush.B", B, 9);
      check("flush.SEL", 32'(SEL), 6);
      tick();
      check("flush.no_issue", 32'(ISSUE), 0);

      // Already-issued command survives a following flush
      drive(OP_ADD, 1, 1, 0, 0, 14);
      tick(); idle();
      tick();
      check("fl2.ISSUE", 32'(ISSUE), 1);
      FLUSH = 1;
      tick();
      FLUSH = 0;
      check("fl2.RES_VALID", 32'(RES_VALID), 1);
      check("fl2.RES_TAG", 32'(RES_TAG), 14);
      check("fl2.R", R, 2);

      // Steady push+issue at COUNT=2 across pointer wrap
      HOLD = 1;
      drive(OP_ADD, 1, 1, 0, 0, 0);
      tick();
      drive(OP_OR, 2, 1, 0, 0, 1);
      tick();
      HOLD = 0;
      for (int i = 0; i < 10; i++) begin
         drive(3'(i % 7), 32'(i + 1), 32'd3, 0, 0, 4'(2 + i));
         tick();
         check("wrap.COUNT", 32'(COUNT), 2);
         if (i > 0) check("wrap.RES_TAG", 32'(RES_TAG), 32'(i - 1));
      end
      idle();
      repeat (4) tick();

      // Asynchronous reset with three entries queued
      HOLD = 1;
      for (int i = 0; i < 4; i++) begin
         drive(OP_ADD, 32'(11 + i), 32'd1, 0, 0, 4'(1 + i));
         tick();
      end
      idle();
      HOLD = 0;
      tick();
      HOLD = 1;
      check("arst.pre_A", A, 11);
      check("arst.pre_COUNT", 32'(COUNT), 3);
      #2 RST = 1;
      #1;
      check("arst.A", A, 0);
      check("arst.B", B, 0);
      check("arst.SEL", 32'(SEL), 0);
      check("arst.ISSUE", 32'(ISSUE), 0);
      check("arst.RES_VALID", 32'(RES_VALID), 0);
      check("arst.COUNT", 32'(COUNT), 0);
      check("arst.IN_READY", 32'(IN_READY), 1);
      tick();
      RST = 0; HOLD = 0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
